// File: rtl/msi_irq_arbiter.sv
// MSI interrupt concentrator: synchronises N sources, detects edge/level requests,
// arbitrates eligible sources (round-robin or fixed priority) onto 2^W MSI vectors.
module msi_irq_arbiter #(
    parameter int unsigned NumberOfInterrupts_Gen = 20,
    parameter logic [63:0] LevelInterrupt_Gen     = 64'h0000_0000_000E_05B8,
    parameter int unsigned PriorityMode_Gen       = 0,
    parameter int unsigned GrantTimeout_Gen       = 1024
) (
    input  logic                              SysClk_ClkIn,
    input  logic                              SysRstN_RstIn,
    input  logic [NumberOfInterrupts_Gen-1:0] IrqIn_DatIn,
    input  logic [NumberOfInterrupts_Gen-1:0] IrqMask_DatIn,
    input  logic                              MsiIrqEnable_EnIn,
    input  logic [2:0]                        MsiVectorWidth_DatIn,
    input  logic                              MsiGrant_ValIn,
    output logic                              MsiReq_ValOut,
    output logic [4:0]                        MsiVectorNum_DatOut,
    output logic [NumberOfInterrupts_Gen-1:0] IrqPending_DatOut,
    output logic [15:0]                       TimeoutCnt_DatOut
);
    localparam int          N        = int'(NumberOfInterrupts_Gen);
    localparam logic [N-1:0] LVL     = LevelInterrupt_Gen[N-1:0];
    localparam bit          TMO_EN   = (GrantTimeout_Gen != 0);
    localparam logic [31:0] TMO_LAST = 32'(GrantTimeout_Gen - 1);

    typedef enum logic [1:0] {IDLE, SELECT, REQUEST, WAITG} state_t;

    state_t r_state;
    (* ASYNC_REG = "TRUE" *) logic [N-1:0] r_sync1;
    (* ASYNC_REG = "TRUE" *) logic [N-1:0] r_sync2;
    logic [N-1:0] r_hist;
    logic [N-1:0] r_pend;
    logic [5:0]   r_ptr;
    logic [5:0]   r_k;
    logic [31:0]  r_timer;
    logic         r_req;
    logic [4:0]   r_vec;
    logic [15:0]  r_tcnt;

    logic [N-1:0] w_det;
    logic [N-1:0] w_elig;
    logic [N-1:0] w_clr;
    logic [2:0]   w_wcl;
    logic [5:0]   w_vmax;
    logic [5:0]   w_first_all;
    logic [5:0]   w_first_hi;
    logic         w_any_hi;
    logic [5:0]   w_k;
    logic [4:0]   w_kvec;
    logic [5:0]   w_knext;
    logic         w_grant;
    logic         w_timeout;

    // Edge sources fire on a 0->1 of the synchronised input; level sources re-fire while high.
    assign w_det     = (~r_hist & r_sync2 & ~LVL) | (r_hist & LVL);
    assign w_elig    = r_pend & ~IrqMask_DatIn;
    assign w_wcl     = (MsiVectorWidth_DatIn > 3'd5) ? 3'd5 : MsiVectorWidth_DatIn;
    assign w_vmax    = (6'd1 << w_wcl) - 6'd1;
    assign w_kvec    = (w_k > w_vmax) ? w_vmax[4:0] : w_k[4:0];
    assign w_knext   = (r_k == 6'(N-1)) ? 6'd0 : r_k + 6'd1;
    assign w_grant   = (r_state == WAITG) && MsiGrant_ValIn;
    assign w_timeout = TMO_EN && (r_timer == TMO_LAST);

    always_comb begin
        w_first_all = '0;
        w_first_hi  = '0;
        w_any_hi    = 1'b0;
        for (int i = N-1; i >= 0; i--) begin
            if (w_elig[i]) w_first_all = 6'(i);
            if (w_elig[i] && (6'(i) >= r_ptr)) begin
                w_first_hi = 6'(i);
                w_any_hi   = 1'b1;
            end
        end
        if (PriorityMode_Gen != 0) w_k = w_first_all;
        else                       w_k = w_any_hi ? w_first_hi : w_first_all;
    end

    always_comb begin
        w_clr = '0;
        for (int i = 0; i < N; i++) w_clr[i] = w_grant && (r_k == 6'(i));
    end

    always_ff @(posedge SysClk_ClkIn or negedge SysRstN_RstIn) begin
        if (!SysRstN_RstIn) begin
            r_state <= IDLE;
            r_sync1 <= '0;
            r_sync2 <= '0;
            r_hist  <= '0;
            r_pend  <= '0;
            r_ptr   <= '0;
            r_k     <= '0;
            r_timer <= '0;
            r_req   <= 1'b0;
            r_vec   <= '0;
            r_tcnt  <= '0;
        end else if (!MsiIrqEnable_EnIn) begin
            r_state <= IDLE;
            r_sync1 <= '0;
            r_sync2 <= '0;
            r_hist  <= '0;
            r_pend  <= '0;
            r_timer <= '0;
            r_req   <= 1'b0;
        end else begin
            r_sync1 <= IrqIn_DatIn;
            r_sync2 <= r_sync1;
            r_hist  <= r_sync2;
            // A detect in the same cycle as the grant clear wins.
            r_pend  <= (r_pend & ~w_clr) | w_det;
            r_req   <= 1'b0;
            case (r_state)
                IDLE: if (|w_elig) r_state <= SELECT;
                SELECT: begin
                    if (|w_elig) begin
                        r_k     <= w_k;
                        r_vec   <= w_kvec;
                        r_req   <= 1'b1;
                        r_state <= REQUEST;
                    end else begin
                        r_state <= IDLE;
                    end
                end
                REQUEST: begin
                    r_timer <= '0;
                    r_state <= WAITG;
                end
                WAITG: begin
                    if (MsiGrant_ValIn) begin
                        r_ptr   <= w_knext;
                        r_state <= IDLE;
                    end else if (w_timeout) begin
                        if (r_tcnt != 16'hFFFF) r_tcnt <= r_tcnt + 16'd1;
                        r_ptr   <= w_knext;
                        r_state <= IDLE;
                    end else begin
                        r_timer <= r_timer + 32'd1;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign MsiReq_ValOut       = r_req;
    assign MsiVectorNum_DatOut = r_vec;
    assign IrqPending_DatOut   = r_pend;
    assign TimeoutCnt_DatOut   = r_tcnt;
endmodule

// File: tb/tb_msi_irq_arbiter.sv
// Bench for msi_irq_arbiter: a round-robin/timeout-16 instance and a fixed-priority/no-timeout
// instance share stimulus and are checked every cycle against a transaction-level model.
module tb_msi_irq_arbiter;
    localparam int          N     = 20;
    localparam logic [63:0] LVL   = 64'h0000_0000_000E_05B8;
    localparam logic [63:0] NMASK = (64'd1 << N) - 64'd1;
    localparam int          MODE_P [2] = '{0, 1};
    localparam int          GT_P   [2] = '{16, 0};

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic [N-1:0]     irq = '0;
    logic [N-1:0]     mask = '0;
    logic             en = 1'b0;
    logic [2:0]       w = 3'd5;
    logic [1:0]       gnt = '0;
    logic [1:0]       o_req;
    logic [1:0][4:0]  o_vec;
    logic [1:0][N-1:0] o_pend;
    logic [1:0][15:0] o_tcnt;

    int n_chk = 0;
    int n_fail = 0;
    int gmode [2] = '{0, 0};   // 0 never grant, 1 grant at once, 2 random (with stray grants)

    // Model state: phase 0 idle, 1 choosing, 2 requesting, 3 waiting for grant
    int          m_phase [2], m_ptr [2], m_k [2], m_timer [2], m_vec [2], m_tcnt [2];
    bit          m_req [2];
    logic [63:0] m_s1 [2], m_s2 [2], m_h [2], m_pend [2];
    int          q0 [$], q1 [$];

    msi_irq_arbiter #(.NumberOfInterrupts_Gen(N), .LevelInterrupt_Gen(LVL),
                      .PriorityMode_Gen(0), .GrantTimeout_Gen(16)) u_rr (
        .SysClk_ClkIn(clk), .SysRstN_RstIn(rst_n), .IrqIn_DatIn(irq), .IrqMask_DatIn(mask),
        .MsiIrqEnable_EnIn(en), .MsiVectorWidth_DatIn(w), .MsiGrant_ValIn(gnt[0]),
        .MsiReq_ValOut(o_req[0]), .MsiVectorNum_DatOut(o_vec[0]),
        .IrqPending_DatOut(o_pend[0]), .TimeoutCnt_DatOut(o_tcnt[0]));

    msi_irq_arbiter #(.NumberOfInterrupts_Gen(N), .LevelInterrupt_Gen(LVL),
                      .PriorityMode_Gen(1), .GrantTimeout_Gen(0)) u_fp (
        .SysClk_ClkIn(clk), .SysRstN_RstIn(rst_n), .IrqIn_DatIn(irq), .IrqMask_DatIn(mask),
        .MsiIrqEnable_EnIn(en), .MsiVectorWidth_DatIn(w), .MsiGrant_ValIn(gnt[1]),
        .MsiReq_ValOut(o_req[1]), .MsiVectorNum_DatOut(o_vec[1]),
        .IrqPending_DatOut(o_pend[1]), .TimeoutCnt_DatOut(o_tcnt[1]));

    initial forever #5 clk = ~clk;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    function automatic int pick(input int d, input logic [63:0] e);
        int idx;
        for (int j = 0; j < N; j++) begin
            idx = (MODE_P[d] != 0) ? j : (m_ptr[d] + j) % N;
            if (e[idx]) return idx;
        end
        return 0;
    endfunction

    task automatic step(input int d);
        logic [63:0] det, e, clrv;
        int wc, vmax;
        det  = ((~m_h[d] & m_s2[d] & ~LVL) | (m_h[d] & LVL)) & NMASK;
        e    = m_pend[d] & ~64'(mask);
        clrv = '0;
        m_req[d] = 1'b0;
        case (m_phase[d])
            0: if (e != 0) m_phase[d] = 1;
            1: if (e == 0) m_phase[d] = 0;
               else begin
                   m_k[d]   = pick(d, e);
                   wc       = (w > 3'd5) ? 5 : int'(w);
                   vmax     = (1 << wc) - 1;
                   m_vec[d] = (m_k[d] > vmax) ? vmax : m_k[d];
                   m_req[d] = 1'b1;
                   m_phase[d] = 2;
               end
            2: begin m_timer[d] = 0; m_phase[d] = 3; end
            default: begin
                if (gnt[d]) begin
                    clrv[m_k[d]] = 1'b1;
                    m_ptr[d]   = (m_k[d] + 1) % N;
                    m_phase[d] = 0;
                end else if (GT_P[d] != 0 && m_timer[d] == GT_P[d] - 1) begin
                    if (m_tcnt[d] < 65535) m_tcnt[d]++;
                    m_ptr[d]   = (m_k[d] + 1) % N;
                    m_phase[d] = 0;
                end else begin
                    m_timer[d]++;
                end
            end
        endcase
        m_pend[d] = (m_pend[d] & ~clrv) | det;
        m_h[d]  = m_s2[d];
        m_s2[d] = m_s1[d];
        m_s1[d] = 64'(irq);
    endtask

    initial begin : model
        forever begin
            @(posedge clk or negedge rst_n);
            for (int d = 0; d < 2; d++) begin
                if (!rst_n) begin
                    m_phase[d] = 0; m_ptr[d] = 0; m_k[d] = 0; m_timer[d] = 0;
                    m_vec[d] = 0; m_tcnt[d] = 0; m_req[d] = 1'b0;
                    m_s1[d] = '0; m_s2[d] = '0; m_h[d] = '0; m_pend[d] = '0;
                end else if (!en) begin
                    m_phase[d] = 0; m_timer[d] = 0; m_req[d] = 1'b0;
                    m_s1[d] = '0; m_s2[d] = '0; m_h[d] = '0; m_pend[d] = '0;
                end else begin
                    step(d);
                end
            end
        end
    end

    initial begin : grant_drv
        forever begin
            @(negedge clk);
            for (int d = 0; d < 2; d++) begin
                case (gmode[d])
                    1:       gnt[d] = (m_phase[d] == 3);
                    2:       gnt[d] = (m_phase[d] == 3) ? ($urandom_range(0, 2) == 0)
                                                        : ($urandom_range(0, 15) == 0);
                    default: gnt[d] = 1'b0;
                endcase
            end
        end
    end

    initial begin : compare
        forever begin
            @(negedge clk);
            if (rst_n) begin
                for (int d = 0; d < 2; d++) begin
                    chk($sformatf("req[%0d]", d),  64'(o_req[d]),  64'(m_req[d]));
                    chk($sformatf("vec[%0d]", d),  64'(o_vec[d]),  64'(m_vec[d]));
                    chk($sformatf("pend[%0d]", d), 64'(o_pend[d]), m_pend[d]);
                    chk($sformatf("tcnt[%0d]", d), 64'(o_tcnt[d]), 64'(m_tcnt[d]));
                    if (o_req[d]) begin
                        if (d == 0) q0.push_back(int'(o_vec[d]));
                        else        q1.push_back(int'(o_vec[d]));
                    end
                end
            end
        end
    end

    task automatic pulse(input logic [N-1:0] m);
        irq = irq | m;
        @(negedge clk);
        irq = irq & ~m;
    endtask

    task automatic wait_req(input int d, input string nm);
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (m_req[d]) return;
        end
        n_chk++; n_fail++;
        $display("FAIL %s: no request within 60 cycles", nm);
    endtask

    task automatic wait_idle(input string nm);
        for (int i = 0; i < 500; i++) begin
            @(negedge clk);
            if (m_phase[0] == 0 && m_phase[1] == 0 && m_pend[0] == 0 && m_pend[1] == 0 &&
                (m_s1[0] | m_s2[0] | m_h[0]) == 0) return;
        end
        n_chk++; n_fail++;
        $display("FAIL %s: not idle within 500 cycles", nm);
    endtask

    task automatic chk_q(input string nm, input int d, input int n,
                         input int e0, input int e1, input int e2, input int e3);
        int sz, v, ex;
        sz = (d == 0) ? q0.size() : q1.size();
        chk({nm, "_count"}, 64'(sz), 64'(n));
        for (int i = 0; i < n && i < sz; i++) begin
            v  = (d == 0) ? q0[i] : q1[i];
            ex = (i == 0) ? e0 : (i == 1) ? e1 : (i == 2) ? e2 : e3;
            chk($sformatf("%s_%0d", nm, i), 64'(v), 64'(ex));
        end
    endtask

    initial begin : main
        repeat (3) @(negedge clk);
        rst_n = 1'b1; en = 1'b1; w = 3'd5;

        // Reset asserted while both instances wait for a grant
        @(negedge clk);
        pulse(N'(1) << 2);
        wait_req(1, "rst_req");
        repeat (3) @(negedge clk);
        #3 rst_n = 1'b0;
        #1;
        for (int d = 0; d < 2; d++) begin
            chk($sformatf("rst_req[%0d]", d),  64'(o_req[d]),  64'd0);
            chk($sformatf("rst_vec[%0d]", d),  64'(o_vec[d]),  64'd0);
            chk($sformatf("rst_pend[%0d]", d), 64'(o_pend[d]), 64'd0);
            chk($sformatf("rst_tcnt[%0d]", d), 64'(o_tcnt[d]), 64'd0);
        end
        @(negedge clk) rst_n = 1'b1;
        repeat (100) begin
            @(negedge clk);
            chk("idle_req", 64'(o_req), 64'd0);
        end

        // Edge on source 0: pending on the 3rd edge, then one request for vector 0
        gmode[0] = 1; gmode[1] = 1;
        q0.delete(); q1.delete();
        @(negedge clk) irq[0] = 1'b1;
        @(negedge clk) irq[0] = 1'b0;
        chk("lat_e1", 64'(o_pend[0][0]), 64'd0);
        @(negedge clk) chk("lat_e2", 64'(o_pend[0][0]), 64'd0);
        @(negedge clk) chk("lat_e3", 64'(o_pend[0][0]), 64'd1);
        chk("lat_e3_fp", 64'(o_pend[1][0]), 64'd1);
        wait_idle("edge0");
        chk_q("edge0_rr", 0, 1, 0, 0, 0, 0);
        chk_q("edge0_fp", 1, 1, 0, 0, 0, 0);
        chk("edge0_pend", 64'(o_pend[0]), 64'd0);

        // Burst 2,5,9
        q0.delete(); q1.delete();
        @(negedge clk);
        pulse((N'(1) << 2) | (N'(1) << 5) | (N'(1) << 9));
        wait_idle("burst1");
        chk_q("burst1_rr", 0, 3, 2, 5, 9, 0);
        chk_q("burst1_fp", 1, 3, 2, 5, 9, 0);

        // Same burst, source 2 re-fires while its first request is outstanding
        q0.delete(); q1.delete();
        @(negedge clk);
        pulse((N'(1) << 2) | (N'(1) << 5) | (N'(1) << 9));
        wait_req(1, "burst2_req");
        pulse(N'(1) << 2);
        wait_idle("burst2");
        chk_q("burst2_rr", 0, 4, 2, 5, 9, 2);
        chk_q("burst2_fp", 1, 4, 2, 2, 5, 9);

        // Folding onto 4 vectors
        w = 3'd2;
        @(negedge clk);
        pulse(N'(1) << 9);
        wait_req(0, "fold_req");
        chk("fold_rr", 64'(o_vec[0]), 64'd3);
        chk("fold_fp", 64'(o_vec[1]), 64'd3);
        wait_idle("fold");
        w = 3'd5;

        // Masked source pends but is never requested until unmasked
        q0.delete(); q1.delete();
        mask[5] = 1'b1;
        @(negedge clk);
        pulse(N'(1) << 5);
        repeat (20) @(negedge clk);
        chk("mask_pend_rr", 64'(o_pend[0][5]), 64'd1);
        chk("mask_pend_fp", 64'(o_pend[1][5]), 64'd1);
        chk_q("mask_noreq_rr", 0, 0, 0, 0, 0, 0);
        mask[5] = 1'b0;
        wait_idle("unmask");
        chk_q("unmask_rr", 0, 1, 5, 0, 0, 0);
        chk_q("unmask_fp", 1, 1, 5, 0, 0, 0);

        // Grant timeout on the round-robin instance
        q0.delete(); q1.delete();
        gmode[0] = 0;
        @(negedge clk);
        pulse(N'(1) << 9);
        wait_req(0, "tmo_req");
        repeat (16) @(negedge clk);
        chk("tmo_before", 64'(o_tcnt[0]), 64'd0);
        @(negedge clk);
        chk("tmo_after", 64'(o_tcnt[0]), 64'd1);
        chk("tmo_pend", 64'(o_pend[0][9]), 64'd1);
        gmode[0] = 1;
        wait_idle("tmo_retry");
        chk("tmo_cleared", 64'(o_pend[0][9]), 64'd0);
        chk_q("tmo_rr", 0, 2, 9, 9, 0, 0);
        chk("tmo_fp_cnt", 64'(o_tcnt[1]), 64'd0);

        // Disabling MSI drops pending but keeps the timeout count
        mask[5] = 1'b1;
        @(negedge clk);
        pulse(N'(1) << 5);
        repeat (10) @(negedge clk);
        chk("dis_pend_before", 64'(o_pend[0][5]), 64'd1);
        en = 1'b0;
        @(negedge clk);
        chk("dis_pend_rr", 64'(o_pend[0]), 64'd0);
        chk("dis_pend_fp", 64'(o_pend[1]), 64'd0);
        chk("dis_tcnt", 64'(o_tcnt[0]), 64'd1);
        en = 1'b1; mask = '0;

        // Randomised traffic
        gmode[0] = 2; gmode[1] = 2;
        for (int c = 0; c < 4000; c++) begin
            @(negedge clk);
            irq = irq ^ N'($urandom & $urandom & $urandom);
            if ($urandom_range(0, 63) == 0) mask = N'($urandom & $urandom & $urandom);
            en = ($urandom_range(0, 299) != 0);
            if ($urandom_range(0, 199) == 0) w = 3'($urandom_range(0, 7));
            if ($urandom_range(0, 399) == 0) gmode[0] = $urandom_range(0, 2);
        end
        irq = '0; mask = '0; en = 1'b1; w = 3'd5;
        gmode[0] = 1; gmode[1] = 1;
        wait_idle("final");

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/msi_irq_arbiter.md
Name: msi_irq_arbiter

Overview:
Parametrised successor MSI interrupt concentrator for the AXI-PCIe bridge MSI interface. It synchronises up to 64 interrupt sources presented as one vector. It detects edge- or level-type requests per source, applies a per-source mask, and arbitrates pending sources in round-robin or fixed-priority order. Sources are folded onto the number of MSI vectors the host allocated. A grant timeout prevents a lost grant from stalling the block.

Parameters:
NumberOfInterrupts_Gen, 20, number of sources N (1..64)
LevelInterrupt_Gen, 64'h0000_0000_000E_05B8, bit i=1: source i is level-type; bit i=0: rising-edge type
PriorityMode_Gen, 0, 0 = round-robin, 1 = fixed priority (lowest index wins)
GrantTimeout_Gen, 1024, cycles to wait for grant after request; 0 = wait forever

Ports:
SysClk_ClkIn  in  1  system clock
SysRstN_RstIn  in  1  reset; asynchronous, active-low
IrqIn_DatIn  in  N  asynchronous interrupt inputs, bit i = source i
IrqMask_DatIn  in  N  1 = source masked; it may become pending but is never selected
MsiIrqEnable_EnIn  in  1  MSI enabled by host
MsiVectorWidth_DatIn  in  3  allocated vectors = 2^W; W limited to 0..5 (values >5 treated as 5)
MsiGrant_ValIn  in  1  bridge grant pulse
MsiReq_ValOut  out  1  one-cycle request pulse
MsiVectorNum_DatOut  out  5  vector for current request
IrqPending_DatOut  out  N  pending register, read-only status
TimeoutCnt_DatOut  out  16  saturating count of grant timeouts

Behaviour:
- Reset values: all outputs 0. Internal sync stages, pending register, pointer and timer are 0. State is Idle.
- Input path: 2-flop synchroniser (ASYNC_REG) followed by one history flop. Edge detect: history=0 and sync=1. Level detect: history=1 and level bit set. A detect sets pending[i]. Latency is rising input -> pending visible on the 3rd clock edge.
- MsiIrqEnable_EnIn=0: state forced to Idle, MsiReq_ValOut=0, synchroniser and pending cleared, timer cleared. Pointer and TimeoutCnt are kept.
- Eligible vector E = pending AND NOT mask.
- Idle: if E≠0, go to Select.
- Select (1 cycle): choose index k.
  - Round-robin: first set bit of E at or above pointer, wrapping to 0.
  - Fixed: lowest set bit of E.
  - If E became 0 in this cycle, return to Idle.
- Request (1 cycle): MsiReq_ValOut=1, MsiVectorNum_DatOut=min(k, 2^W-1). Sources beyond the allocated range share the top vector. Timer is loaded with 0.
- WaitGrant: MsiReq_ValOut=0; MsiVectorNum_DatOut is held until the next Request.
  - On MsiGrant_ValIn=1: clear pending[k], set pointer=(k+1) mod N, go to Idle.
  - If timer reaches GrantTimeout_Gen-1 without grant (GrantTimeout_Gen≠0): increment TimeoutCnt (saturates at 16'hFFFF), keep pending[k], set pointer=(k+1) mod N, go to Idle.
  - Grant and timeout in the same cycle: grant wins.
- Grant outside WaitGrant is ignored.
- Same-cycle set and clear of pending[k]: set wins, so a fresh edge is not lost. A level source that is still high re-pends by the same rule.
- Masking k while in WaitGrant does not abort the request.
- Changes to W take effect at the next Request.
- Best-case throughput: one request per 4 cycles (Idle, Select, Request, grant cycle).

Test Plan:
- Reset/idle: SysRstN_RstIn low mid-WaitGrant -> all outputs 0 immediately. After release with no inputs, MsiReq_ValOut stays 0 for 100 cycles.
- Edge source 0 pulses 1 cycle with enable=1, W=5 -> pending[0] set on 3rd edge. One MsiReq_ValOut pulse with vector 0. After grant, pending=0.
- Round-robin: sources 2, 5, 9 edge together, mode 0, immediate grants -> vectors 2, 5, 9 in that order. Repeating the burst with mode 1 and source 2 re-asserted after its grant -> order 2, 2, 5, 9.
- Folding: W=2, source 9 edge -> MsiVectorNum_DatOut=3.
- Mask: mask[5]=1 with source 5 edge -> pending[5]=1 and no request. Unmask -> request with vector 5.
- Timeout: GrantTimeout_Gen=16, no grant -> TimeoutCnt=1 after 16 WaitGrant cycles and pending stays set. Re-request follows. Grant on the second attempt clears pending.
